// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/and/slt/shifts, iterative shift-add multiply and
// restoring divide/remainder, with a valid/ready handshake on both sides.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_DIV = 4'b1100;
  localparam logic [3:0] OP_REM = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             err_q, err_d, zero_q, zero_d;

  function automatic logic [WIDTH-1:0] single_result(input logic [3:0] op,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
    // B >= WIDTH is detected by any bit set above the shift-amount field
    logic big;
    big = |b[WIDTH-1:SHW];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  return big ? '0 : (a << b[SHW-1:0]);
      OP_SRL:  return big ? '0 : (a >> b[SHW-1:0]);
      OP_DIV:  return '1;
      OP_REM:  return a;
      default: return '0;
    endcase
  endfunction

  function automatic logic single_err(input logic [3:0] op, input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_SRL, OP_MUL: return 1'b0;
      OP_DIV, OP_REM: return (b == '0);
      default: return 1'b1;
    endcase
  endfunction

  logic [WIDTH-1:0] mul_step;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] single_r;
  logic [WIDTH-1:0] iter_r;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    dout_d   = dout_q;
    err_d    = err_q;
    zero_d   = zero_q;
    single_r = single_result(opcode, data1, data2);

    // One iteration step: multiply consumes B MSB-first, divide brings down A MSB-first
    mul_step  = (acc_q[WIDTH-1:0] << 1) + (b_q[cnt_q] ? a_q : '0);
    div_trial = {acc_q[WIDTH-1:0], a_q[cnt_q]};
    div_rem   = div_trial;
    div_quo   = quo_q;
    if (div_trial >= {1'b0, b_q}) begin
      div_rem          = div_trial - {1'b0, b_q};
      div_quo[cnt_q]   = 1'b1;
    end
    case (op_q)
      OP_MUL:  iter_r = mul_step;
      OP_DIV:  iter_r = div_quo;
      default: iter_r = div_rem[WIDTH-1:0];
    endcase

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = opcode;
          a_d   = data1;
          b_d   = data2;
          acc_d = '0;
          quo_d = '0;
          cnt_d = SHW'(WIDTH - 1);
          if (opcode == OP_MUL ||
              ((opcode == OP_DIV || opcode == OP_REM) && data2 != '0)) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            dout_d  = single_r;
            err_d   = single_err(opcode, data2);
            zero_d  = (single_r == '0);
          end
        end
      end
      S_BUSY: begin
        acc_d = (op_q == OP_MUL) ? {1'b0, mul_step} : div_rem;
        quo_d = div_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          dout_d  = iter_r;
          err_d   = 1'b0;
          zero_d  = (iter_r == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign data_out  = dout_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written handshake/reset
// sequences, and random operations against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   opcode;
  logic [W-1:0] data1, data2;
  logic         in_valid, in_ready;
  logic [W-1:0] data_out;
  logic         zero, err, out_valid, out_ready;

  int checks = 0;
  int passes = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .data1(data1), .data2(data2),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .zero(zero),
    .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         e;
    int           lat;
    string        nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain arithmetic on wide integers, then truncate to W bits
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic e, output int lat);
    longint la, lb, m, v;
    la = a; lb = b; m = (longint'(1) << W) - 1;
    e = 1'b0; lat = 0;
    case (op)
      4'd2:  v = (la + lb) & m;
      4'd3:  v = (la - lb) & m;
      4'd7:  v = la & lb;
      4'd8:  v = (la < lb) ? 1 : 0;
      4'd9:  v = (lb >= W) ? 0 : ((la << lb) & m);
      4'd10: v = (lb >= W) ? 0 : (la >> lb);
      4'd11: begin v = (la * lb) & m; lat = W; end
      4'd12: if (lb == 0) begin v = m; e = 1'b1; end else begin v = la / lb; lat = W; end
      4'd13: if (lb == 0) begin v = la; e = 1'b1; end else begin v = la % lb; lat = W; end
      default: begin v = 0; e = 1'b1; end
    endcase
    r = v[W-1:0];
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input logic exp_e, input int exp_lat,
                        input string nm);
    int lat;
    bit busy_bad;
    @(negedge clock);
    chk({nm, ".in_ready"}, in_ready, 1);
    opcode = op; data1 = a; data2 = b; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    opcode = 4'($urandom); data1 = W'($urandom); data2 = W'($urandom);
    lat = 0; busy_bad = 0;
    while (!out_valid && lat < 4 * W) begin
      if (in_ready) busy_bad = 1;
      @(negedge clock);
      lat++;
    end
    chk({nm, ".latency"}, lat, exp_lat);
    chk({nm, ".in_ready_busy"}, busy_bad, 0);
    chk({nm, ".data"}, data_out, exp_r);
    chk({nm, ".err"}, err, exp_e);
    chk({nm, ".zero"}, zero, (exp_r == '0));
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({nm, ".taken"}, out_valid, 0);
  endtask

  vec_t vecs[12];

  initial begin
    logic [W-1:0] r, held;
    logic         e;
    int           lat;

    vecs[0]  = '{4'd2,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 0,  "add_wrap"};
    vecs[1]  = '{4'd3,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 0,  "sub_wrap"};
    vecs[2]  = '{4'd7,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 0,  "and"};
    vecs[3]  = '{4'd8,  16'h0002, 16'h0007, 16'h0001, 1'b0, 0,  "slt"};
    vecs[4]  = '{4'd9,  16'h0001, 16'd15,   16'h8000, 1'b0, 0,  "sll15"};
    vecs[5]  = '{4'd10, 16'h8000, 16'd20,   16'h0000, 1'b0, 0,  "srl20"};
    vecs[6]  = '{4'd11, 16'd300,  16'd300,  16'h5F90, 1'b0, W,  "mul"};
    vecs[7]  = '{4'd12, 16'd1000, 16'd7,    16'd142,  1'b0, W,  "div"};
    vecs[8]  = '{4'd13, 16'd1000, 16'd7,    16'd6,    1'b0, W,  "rem"};
    vecs[9]  = '{4'd12, 16'd5,    16'd0,    16'hFFFF, 1'b1, 0,  "div0"};
    vecs[10] = '{4'd13, 16'd5,    16'd0,    16'd5,    1'b1, 0,  "rem0"};
    vecs[11] = '{4'd0,  16'h1234, 16'h5678, 16'h0000, 1'b1, 0,  "illegal"};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; data1 = '0; data2 = '0;
    repeat (2) @(negedge clock);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.data_out", data_out, 0);
    chk("rst.zero", zero, 0);
    chk("rst.err", err, 0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].e, vecs[i].lat, vecs[i].nm);

    // Reset three cycles into a multiply discards it immediately
    run_op(4'd2, 16'd2, 16'd3, 16'd5, 1'b0, 0, "pre_add");
    @(negedge clock);
    opcode = 4'd11; data1 = 16'd300; data2 = 16'd300; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.data_out", data_out, 0);
    chk("midrst.in_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    run_op(4'd2, 16'd2, 16'd3, 16'd5, 1'b0, 0, "post_rst_add");

    // Backpressure: result held while the consumer stalls, new requests ignored
    @(negedge clock);
    opcode = 4'd11; data1 = 16'd300; data2 = 16'd300; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin @(negedge clock); lat++; end
    chk("bp.latency", lat, W);
    held = data_out;
    chk("bp.data", held, 16'h5F90);
    opcode = 4'd2; data1 = 16'd1; data2 = 16'd1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (data_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1)
        chk($sformatf("bp.stall%0d", k), {data_out, 7'd0, in_ready, out_valid}, {held, 9'b000000001});
    end
    chk("bp.held_after_stall", data_out, 16'h5F90);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp.released_valid", out_valid, 0);
    chk("bp.released_ready", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp.next_valid", out_valid, 1);
    chk("bp.next_data", data_out, 16'd2);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;

    // Random operations, biased toward small B to reach shift limits and divide by zero
    for (int n = 0; n < 40; n++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      case ($urandom_range(0, 9))
        0: op = 4'($urandom);
        1: op = 4'd2; 2: op = 4'd3; 3: op = 4'd7; 4: op = 4'd8;
        5: op = 4'($urandom_range(9, 10));
        6, 7: op = 4'd11;
        default: op = 4'($urandom_range(12, 13));
      endcase
      a = W'($urandom);
      b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      ref_model(op, a, b, r, e, lat);
      run_op(op, a, b, r, e, lat, $sformatf("rnd%0d_op%0d", n, op));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. Accepts one operation at a time through a valid/ready handshake. Single-cycle ops (add, sub, and, slt, sll, srl) return after one cycle; iterative ops (mul, div, rem) take WIDTH cycles. Sits between the register-file read stage and write-back, and can stall the pipeline through `in_ready` / `out_valid`.

## Interface
- `WIDTH`, 16: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount field width; derived, not overridden.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `opcode` in 4: operation select, sampled on accept.
- `data1` in WIDTH: operand A, sampled on accept.
- `data2` in WIDTH: operand B, sampled on accept.
- `in_valid` in 1: operands/opcode valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `data_out` out WIDTH: registered result, stable while `out_valid`.
- `zero` out 1: `data_out == 0`.
- `err` out 1: illegal opcode or division by zero.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.

## Operation
- Opcodes (unsigned unless stated):
  - 0010 add: A+B mod 2^WIDTH.
  - 0011 sub: A−B mod 2^WIDTH.
  - 0111 and: bitwise A&B.
  - 1000 slt: 1 if A<B, else 0.
  - 1001 sll: A<<B[SHW-1:0], or 0 if B ≥ WIDTH.
  - 1010 srl: logical A>>B[SHW-1:0], or 0 if B ≥ WIDTH.
  - 1011 mul: low WIDTH bits of A*B, shift-add.
  - 1100 div: A/B, restoring division.
  - 1101 rem: A%B, restoring division.
- Any other opcode: `data_out` = 0, `err` = 1, single-cycle.
- Divide by zero (div/rem with B=0): no iteration, single-cycle. div gives all-ones; rem gives A; `err` = 1.
- `zero` is computed from the final result and updates with `data_out`.
- FSM:
  - IDLE: `in_ready` = 1.
  - Accept (`in_valid & in_ready`) → BUSY for mul, or for div/rem with B≠0. All other ops → DONE, with the result registered in the same edge.
  - BUSY: iteration counter runs WIDTH−1 down to 0, one step per cycle. Leaves for DONE on the edge that completes step 0.
  - DONE: `out_valid` = 1; outputs held. `out_ready` → IDLE.
- Inputs are ignored outside IDLE. Operands are latched internally, so input changes during BUSY have no effect.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `data_out` 0, `zero` 0, `err` 0, counter 0.
- Single-cycle op accepted at edge N: `out_valid` high after edge N; consumer can take it at edge N+1.
- Iterative op accepted at edge N: BUSY for WIDTH cycles; `out_valid` high after edge N+WIDTH.
- Handshake:
  - `in_ready` is low from accept until the result is taken.
  - Next accept is possible at the edge after the `out_ready` edge, so the minimum single-cycle throughput is one op per 2 cycles.
  - `out_ready` high during IDLE/BUSY has no effect.
  - `out_valid` stays high with `data_out` stable until `out_ready`. An unlimited stall is legal.
- Reset asserted mid-BUSY or in DONE: immediate return to reset values; the in-flight result is discarded. First accept is allowed on the first edge after deassertion.
- Widths: sub wraps (0−1 = all-ones). mul discards upper WIDTH bits. Shift uses only the low SHW bits of B after the ≥ WIDTH check.

## Test plan
- Reset mid-mul: drive `reset` 3 cycles after accepting a mul. Required: `out_valid` = 0 and `data_out` = 0 immediately. A following add 2+3 returns 5.
- Single-cycle ops, WIDTH=16, `out_ready` held 1:
  - add 0xFFFF+1 → 0, `zero` = 1.
  - sub 3−5 → 0xFFFE.
  - and 0xF0F0&0x3C3C → 0x3030.
  - slt 2,7 → 1.
  - sll 1,15 → 0x8000.
  - srl 0x8000,20 → 0.
  - `out_valid` one cycle after each accept.
- mul 300*300 → 0x5F90. `out_valid` exactly 16 cycles after accept; `in_ready` low throughout.
- div 1000/7 → 142, rem 1000%7 → 6, 16 cycles each.
- div 5/0 → 0xFFFF and rem 5%0 → 5, both with `err` = 1, single-cycle. Opcode 0000 → 0 with `err` = 1.
- Backpressure: hold `out_ready` 0 for 10 cycles after a mul result. Required: `data_out` stable, `in_ready` 0, and a second `in_valid` ignored. Raise `out_ready`; the next op is accepted one cycle later.
